atm_keypad_entry: RTL and testbench
===================================

// Module: atm_keypad_entry
// PURPOSE
//  Front-panel keypad sequencer that drives the ATM controller's request interface. Collects
//  decimal key presses and assembles account number, PIN, menu option, amount and destination.
//  Presents each completed request on a valid/ready handshake and pulses exit on cancel/logout.
//  Sits between the keypad scanner and the ATM core; one key event is consumed per cycle.
// PARAMETERS
//  MAX_DIGITS      4     max decimal digits for account/amount/destination fields
//  ACC_MAX         4095  largest legal account number (12-bit)
//  AMT_MAX         2047  largest legal amount (11-bit)
//  TIMEOUT_CYCLES  1000  idle cycles before auto-cancel (only with KEYPAD_TIMEOUT_EN)
// PORTS
//  clk          in   1   clock
//  rst          in   1   reset, asynchronous, active-high
//  key_valid    in   1   key_code valid this cycle (single-cycle strobe per press)
//  key_code     in   4   0-9 digit, 0xA ENTER, 0xB CLEAR, 0xC CANCEL, 0xD-0xF ignored
//  req_ready    in   1   ATM core accepts request when req_valid & req_ready
//  req_valid    out  1   request pending; payload stable while high
//  req_kind     out  1   0 = login (acc_number+pin), 1 = transaction (menu_option+amount+dest_acc)
//  acc_number   out  12  account number
//  pin          out  4   PIN (single decimal digit 0-9)
//  menu_option  out  3   3 BALANCE, 4 WITHDRAW, 5 WITHDRAW_SHOW, 6 TRANSFER, 7 DEPOSIT
//  amount       out  11  transaction amount
//  dest_acc     out  12  transfer destination account
//  exit_pulse   out  1   1-cycle logout strobe
//  entry_error  out  1   1-cycle strobe on rejected entry
//  timeout      out  1   1-cycle strobe on idle timeout (tied 0 without KEYPAD_TIMEOUT_EN)
//  state_dbg    out  3   current FSM state encoding
// BEHAVIOUR
//  - Reset: all outputs 0, accumulator/digit count 0, state S_ACC. Async reset mid-request drops it.
//  - States (state_dbg): S_ACC=0, S_PIN=1, S_LREQ=2, S_MENU=3, S_AMT=4, S_DEST=5, S_TREQ=6.
//  - Digit in field state: acc <= acc*10 + digit (14-bit accumulator), cnt++. Digit when
//    cnt==MAX_DIGITS is dropped and entry_error pulses. CLEAR: acc<=0, cnt<=0, state kept.
//  - ENTER with cnt==0: entry_error, state kept. ENTER with value over field limit
//    (ACC_MAX/AMT_MAX, pin>9, menu not in {0,3..7}): entry_error, field cleared, state kept.
//  - S_ACC ENTER ok -> acc_number latched, S_PIN. S_PIN: one digit then ENTER -> pin, S_LREQ.
//  - S_LREQ: req_valid=1, req_kind=0 registered same edge as entry; on req_valid&req_ready
//    req_valid falls next edge, state S_MENU. Login rejection is reported by the core,
//    which then asserts exit via its own path; this block stays in S_MENU until CANCEL/0.
//  - S_MENU ENTER: 0 -> logout (exit_pulse, clear all, S_ACC); 3 -> menu_option, S_TREQ;
//    4/5/7 -> S_AMT; 6 -> S_AMT then S_DEST. Amount ENTER -> S_TREQ (or S_DEST if option 6).
//  - S_TREQ: req_valid=1, req_kind=1; accept -> S_MENU, amount/dest_acc cleared to 0.
//  - Keys while req_valid=1 are ignored (no error), including CANCEL.
//  - CANCEL in any non-request state: exit_pulse 1 cycle, all payload regs 0, S_ACC.
//  - key_valid and req handshake same cycle: handshake wins, key discarded.
//  - Payload outputs never change while req_valid=1.
// CONFIGURATION
//  KEYPAD_TIMEOUT_EN defined: 32-bit idle counter cleared on any accepted key or state change;
//   in S_PIN..S_DEST (excluding S_LREQ/S_TREQ) reaching TIMEOUT_CYCLES performs CANCEL
//   action plus timeout pulse same cycle as exit_pulse. S_ACC with cnt==0 never times out.
//  Not defined: no counter, timeout held 0, no auto-cancel.
// TESTING
//  - Keys 2,7,4,9,ENT,0,ENT, ready low 3 cyc -> req_valid=1 kind=0 acc=2749 pin=0 stable; ready=1 -> S_MENU.
//  - From S_MENU: 4,ENT,1,0,0,ENT, ready=1 -> kind=1 menu=4 amount=100; then S_MENU, amount=0.
//  - 6,ENT,5,0,ENT,2,1,7,5,ENT -> menu=6 amount=50 dest_acc=2175 on one request.
//  - Acc 5,0,0,0,ENT -> entry_error, stays S_ACC cnt=0; 1,2,3,4,5 -> 5th digit errors, acc accum=1234.
//  - CANCEL in S_AMT -> exit_pulse 1 cyc, S_ACC, outputs 0; key during S_TREQ ignored.
//  - KEYPAD_TIMEOUT_EN, TIMEOUT_CYCLES=20: idle 20 cyc in S_PIN -> timeout+exit_pulse, S_ACC.

Source files
------------

// File: rtl/atm_keypad_entry_if.sv
// Request/keypad bundle between the keypad scanner, atm_keypad_entry and the ATM core.
// master = atm_keypad_entry side, slave = scanner/core side.
interface atm_keypad_entry_if;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        req_ready;
    logic        req_valid;
    logic        req_kind;
    logic [11:0] acc_number;
    logic [3:0]  pin;
    logic [2:0]  menu_option;
    logic [10:0] amount;
    logic [11:0] dest_acc;
    logic        exit_pulse;
    logic        entry_error;
    logic        timeout;
    logic [2:0]  state_dbg;

    modport master (
        input  key_valid, key_code, req_ready,
        output req_valid, req_kind, acc_number, pin, menu_option, amount, dest_acc,
               exit_pulse, entry_error, timeout, state_dbg
    );

    modport slave (
        output key_valid, key_code, req_ready,
        input  req_valid, req_kind, acc_number, pin, menu_option, amount, dest_acc,
               exit_pulse, entry_error, timeout, state_dbg
    );
endinterface

// File: rtl/atm_keypad_entry.sv
// Keypad sequencer assembling login/transaction requests for the ATM core.
// Optional idle auto-cancel enabled by defining KEYPAD_TIMEOUT_EN.
module atm_keypad_entry #(
    parameter int MAX_DIGITS = 4,
    parameter int ACC_MAX    = 4095,
    parameter int AMT_MAX    = 2047
`ifdef KEYPAD_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 1000
`endif
) (
    input  logic               clk,
    input  logic               rst,
    atm_keypad_entry_if.master bus
);

    typedef enum logic [2:0] {
        S_ACC  = 3'd0,
        S_PIN  = 3'd1,
        S_LREQ = 3'd2,
        S_MENU = 3'd3,
        S_AMT  = 3'd4,
        S_DEST = 3'd5,
        S_TREQ = 3'd6
    } state_t;

    localparam logic [3:0]  KEY_ENTER  = 4'hA;
    localparam logic [3:0]  KEY_CLEAR  = 4'hB;
    localparam logic [3:0]  KEY_CANCEL = 4'hC;
    localparam logic [2:0]  CNT_MAX    = 3'(MAX_DIGITS);
    localparam logic [13:0] ACC_LIM    = 14'(ACC_MAX);
    localparam logic [13:0] AMT_LIM    = 14'(AMT_MAX);

    state_t      state, state_nxt;
    logic [13:0] acc;
    logic [2:0]  cnt;
    logic [11:0] acc_number_q, dest_acc_q;
    logic [3:0]  pin_q;
    logic [2:0]  menu_q;
    logic [10:0] amount_q;
    logic        exit_q, err_q;
    logic        req_valid_o, req_kind_o;

    logic        req_state, key_acc, is_digit, over, to_hit;
    logic        fld_clr, fld_dig, err, do_exit;
    logic        lat_acc, lat_pin, lat_menu, lat_amt, lat_dest, tx_done;

    // Keys are only consumed outside request states, so a handshake always wins.
    assign req_state = (state == S_LREQ) || (state == S_TREQ);
    assign key_acc   = bus.key_valid && !req_state && (bus.key_code <= KEY_CANCEL);
    assign is_digit  = bus.key_code <= 4'd9;

    always_comb begin
        over = 1'b0;
        case (state)
            S_ACC, S_DEST: over = acc > ACC_LIM;
            S_AMT:         over = acc > AMT_LIM;
            S_PIN:         over = acc > 14'd9;
            S_MENU:        over = (acc == 14'd1) || (acc == 14'd2) || (acc > 14'd7);
            default:       over = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_ACC;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        fld_clr   = 1'b0;
        fld_dig   = 1'b0;
        err       = 1'b0;
        do_exit   = 1'b0;
        lat_acc   = 1'b0;
        lat_pin   = 1'b0;
        lat_menu  = 1'b0;
        lat_amt   = 1'b0;
        lat_dest  = 1'b0;
        tx_done   = 1'b0;
        case (state)
            S_LREQ: if (bus.req_ready) state_nxt = S_MENU;
            S_TREQ: begin
                if (bus.req_ready) begin
                    state_nxt = S_MENU;
                    tx_done   = 1'b1;
                end
            end
            default: begin
                if (key_acc) begin
                    if (bus.key_code == KEY_CANCEL) begin
                        do_exit   = 1'b1;
                        state_nxt = S_ACC;
                    end else if (bus.key_code == KEY_CLEAR) begin
                        fld_clr = 1'b1;
                    end else if (is_digit) begin
                        if (cnt == CNT_MAX) err = 1'b1;
                        else                fld_dig = 1'b1;
                    end else if (cnt == 3'd0) begin
                        err = 1'b1;
                    end else if (over) begin
                        err     = 1'b1;
                        fld_clr = 1'b1;
                    end else begin
                        fld_clr = 1'b1;
                        case (state)
                            S_ACC: begin
                                lat_acc   = 1'b1;
                                state_nxt = S_PIN;
                            end
                            S_PIN: begin
                                lat_pin   = 1'b1;
                                state_nxt = S_LREQ;
                            end
                            S_MENU: begin
                                if (acc == 14'd0) begin
                                    do_exit   = 1'b1;
                                    state_nxt = S_ACC;
                                end else begin
                                    lat_menu  = 1'b1;
                                    state_nxt = (acc == 14'd3) ? S_TREQ : S_AMT;
                                end
                            end
                            S_AMT: begin
                                lat_amt   = 1'b1;
                                state_nxt = (menu_q == 3'd6) ? S_DEST : S_TREQ;
                            end
                            S_DEST: begin
                                lat_dest  = 1'b1;
                                state_nxt = S_TREQ;
                            end
                            default: ;
                        endcase
                    end
                end else if (to_hit) begin
                    do_exit   = 1'b1;
                    state_nxt = S_ACC;
                end
            end
        endcase
    end

    always_comb begin
        req_valid_o = 1'b0;
        req_kind_o  = 1'b0;
        case (state)
            S_LREQ: req_valid_o = 1'b1;
            S_TREQ: begin
                req_valid_o = 1'b1;
                req_kind_o  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc          <= '0;
            cnt          <= '0;
            acc_number_q <= '0;
            pin_q        <= '0;
            menu_q       <= '0;
            amount_q     <= '0;
            dest_acc_q   <= '0;
            exit_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            exit_q <= do_exit;
            err_q  <= err;
            if (do_exit) begin
                acc          <= '0;
                cnt          <= '0;
                acc_number_q <= '0;
                pin_q        <= '0;
                menu_q       <= '0;
                amount_q     <= '0;
                dest_acc_q   <= '0;
            end else begin
                if (fld_clr) begin
                    acc <= '0;
                    cnt <= '0;
                end else if (fld_dig) begin
                    acc <= acc * 14'd10 + {10'd0, bus.key_code};
                    cnt <= cnt + 3'd1;
                end
                if (lat_acc)  acc_number_q <= acc[11:0];
                if (lat_pin)  pin_q        <= acc[3:0];
                if (lat_menu) menu_q       <= acc[2:0];
                if (lat_amt)  amount_q     <= acc[10:0];
                if (lat_dest) dest_acc_q   <= acc[11:0];
                if (tx_done) begin
                    amount_q   <= '0;
                    dest_acc_q <= '0;
                end
            end
        end
    end

`ifdef KEYPAD_TIMEOUT_EN
    logic [31:0] idle_cnt;
    logic        timeable, timeout_q;

    // An empty account field never times out; request states wait on the core instead.
    assign timeable = (state == S_PIN) || (state == S_MENU) || (state == S_AMT) ||
                      (state == S_DEST) || ((state == S_ACC) && (cnt != 3'd0));
    assign to_hit   = timeable && !key_acc && (idle_cnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= to_hit;
            if (key_acc || (state_nxt != state)) idle_cnt <= '0;
            else                                 idle_cnt <= idle_cnt + 32'd1;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign to_hit      = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    assign bus.req_valid   = req_valid_o;
    assign bus.req_kind    = req_kind_o;
    assign bus.acc_number  = acc_number_q;
    assign bus.pin         = pin_q;
    assign bus.menu_option = menu_q;
    assign bus.amount      = amount_q;
    assign bus.dest_acc    = dest_acc_q;
    assign bus.exit_pulse  = exit_q;
    assign bus.entry_error = err_q;
    assign bus.state_dbg   = state;

endmodule

// File: tb/tb_atm_keypad_entry.sv
// Directed scoreboard bench for atm_keypad_entry; expected requests are queued as keys are sent.
module tb_atm_keypad_entry;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    atm_keypad_entry_if bus();

`ifdef KEYPAD_TIMEOUT_EN
    atm_keypad_entry #(.TIMEOUT_CYCLES(20)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
    atm_keypad_entry dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    typedef struct {
        logic        kind;
        logic [11:0] acc;
        logic [3:0]  pin;
        logic [2:0]  menu;
        logic [10:0] amt;
        logic [11:0] dest;
    } req_t;

    localparam logic [3:0] K_ENT = 4'hA;
    localparam logic [3:0] K_CLR = 4'hB;
    localparam logic [3:0] K_CAN = 4'hC;
    localparam int ST_ACC = 0, ST_PIN = 1, ST_LREQ = 2, ST_MENU = 3, ST_AMT = 4, ST_DEST = 5, ST_TREQ = 6;

    req_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] c);
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_code  = c;
        @(negedge clk);
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
    endtask

    task automatic digits(input int v, input int nd);
        int d = 1;
        for (int i = 1; i < nd; i++) d *= 10;
        for (int i = 0; i < nd; i++) begin
            press(4'((v / d) % 10));
            d /= 10;
        end
    endtask

    task automatic enter_num(input int v, input int nd);
        digits(v, nd);
        press(K_ENT);
    endtask

    task automatic push(input logic kind, input int acc, input int pin, input int menu,
                        input int amt, input int dest);
        req_t r;
        r.kind = kind;
        r.acc  = 12'(acc);
        r.pin  = 4'(pin);
        r.menu = 3'(menu);
        r.amt  = 11'(amt);
        r.dest = 12'(dest);
        sb.push_back(r);
    endtask

    // Waits (bounded) for a request, pops the expected one and holds ready low for `hold` cycles.
    task automatic wait_req(input int hold);
        req_t e;
        int   n = 0;
        while (bus.req_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_valid_seen", 32'(bus.req_valid), 32'd1);
        chk("sb_depth", 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            for (int i = 0; i <= hold; i++) begin
                chk("req_valid_hold", 32'(bus.req_valid), 32'd1);
                chk("req_kind", 32'(bus.req_kind), 32'(e.kind));
                chk("acc_number", 32'(bus.acc_number), 32'(e.acc));
                chk("pin", 32'(bus.pin), 32'(e.pin));
                chk("menu_option", 32'(bus.menu_option), 32'(e.menu));
                chk("amount", 32'(bus.amount), 32'(e.amt));
                chk("dest_acc", 32'(bus.dest_acc), 32'(e.dest));
                if (i < hold) @(negedge clk);
            end
        end
    endtask

    task automatic accept(input bit txn);
        @(negedge clk);
        bus.req_ready = 1'b1;
        @(negedge clk);
        bus.req_ready = 1'b0;
        chk("req_valid_drop", 32'(bus.req_valid), 32'd0);
        chk("state_after_accept", 32'(bus.state_dbg), ST_MENU);
        if (txn) begin
            chk("amount_cleared", 32'(bus.amount), 32'd0);
            chk("dest_cleared", 32'(bus.dest_acc), 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        bus.req_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_state", 32'(bus.state_dbg), ST_ACC);
        chk("rst_req_valid", 32'(bus.req_valid), 32'd0);
        chk("rst_exit", 32'(bus.exit_pulse), 32'd0);
        chk("rst_err", 32'(bus.entry_error), 32'd0);
        chk("rst_acc_number", 32'(bus.acc_number), 32'd0);
        chk("rst_timeout", 32'(bus.timeout), 32'd0);
        rst = 1'b0;

        // Login 2749 / PIN 0, core stalls 3 cycles
        enter_num(2749, 4);
        chk("state_pin", 32'(bus.state_dbg), ST_PIN);
        chk("acc_latched", 32'(bus.acc_number), 32'd2749);
        push(1'b0, 2749, 0, 0, 0, 0);
        enter_num(0, 1);
        wait_req(3);
        accept(1'b0);

        // Withdraw 100
        enter_num(4, 1);
        chk("state_amt", 32'(bus.state_dbg), ST_AMT);
        push(1'b1, 2749, 0, 4, 100, 0);
        enter_num(100, 3);
        wait_req(1);
        accept(1'b1);

        // Balance; keys (even CANCEL) ignored while the request is pending
        push(1'b1, 2749, 0, 3, 0, 0);
        enter_num(3, 1);
        wait_req(1);
        press(K_CAN);
        chk("cancel_ignored_exit", 32'(bus.exit_pulse), 32'd0);
        chk("cancel_ignored_valid", 32'(bus.req_valid), 32'd1);
        chk("cancel_ignored_state", 32'(bus.state_dbg), ST_TREQ);
        press(4'd5);
        chk("digit_ignored_err", 32'(bus.entry_error), 32'd0);
        accept(1'b1);

        // Transfer 50 to 2175
        enter_num(6, 1);
        enter_num(50, 2);
        chk("state_dest", 32'(bus.state_dbg), ST_DEST);
        push(1'b1, 2749, 0, 6, 50, 2175);
        enter_num(2175, 4);
        wait_req(1);
        accept(1'b1);

        // Illegal menu option
        enter_num(2, 1);
        chk("menu2_err", 32'(bus.entry_error), 32'd1);
        chk("menu2_state", 32'(bus.state_dbg), ST_MENU);
        @(negedge clk);
        chk("err_one_cycle", 32'(bus.entry_error), 32'd0);

        // CANCEL in S_AMT
        enter_num(7, 1);
        chk("state_amt_dep", 32'(bus.state_dbg), ST_AMT);
        digits(12, 2);
        press(K_CAN);
        chk("cancel_exit", 32'(bus.exit_pulse), 32'd1);
        chk("cancel_state", 32'(bus.state_dbg), ST_ACC);
        chk("cancel_acc", 32'(bus.acc_number), 32'd0);
        chk("cancel_menu", 32'(bus.menu_option), 32'd0);
        @(negedge clk);
        chk("exit_one_cycle", 32'(bus.exit_pulse), 32'd0);

        // Account over limit, empty ENTER, fifth digit
        enter_num(5000, 4);
        chk("acc5000_err", 32'(bus.entry_error), 32'd1);
        chk("acc5000_state", 32'(bus.state_dbg), ST_ACC);
        press(K_ENT);
        chk("empty_enter_err", 32'(bus.entry_error), 32'd1);
        digits(1234, 4);
        press(4'd5);
        chk("fifth_digit_err", 32'(bus.entry_error), 32'd1);
        press(K_ENT);
        chk("acc1234_state", 32'(bus.state_dbg), ST_PIN);
        chk("acc1234", 32'(bus.acc_number), 32'd1234);

        // PIN over 9, empty ENTER, CLEAR
        enter_num(12, 2);
        chk("pin12_err", 32'(bus.entry_error), 32'd1);
        chk("pin12_state", 32'(bus.state_dbg), ST_PIN);
        press(K_ENT);
        chk("pin_empty_err", 32'(bus.entry_error), 32'd1);
        press(4'd5);
        press(K_CLR);
        push(1'b0, 1234, 7, 0, 0, 0);
        enter_num(7, 1);
        wait_req(0);
        accept(1'b0);

        // Amount boundary 2048/2047, then handshake collides with a CANCEL key
        enter_num(4, 1);
        enter_num(2048, 4);
        chk("amt2048_err", 32'(bus.entry_error), 32'd1);
        chk("amt2048_state", 32'(bus.state_dbg), ST_AMT);
        push(1'b1, 1234, 7, 4, 2047, 0);
        enter_num(2047, 4);
        wait_req(0);
        @(negedge clk);
        bus.req_ready = 1'b1;
        bus.key_valid = 1'b1;
        bus.key_code  = K_CAN;
        @(negedge clk);
        bus.req_ready = 1'b0;
        bus.key_valid = 1'b0;
        chk("collide_state", 32'(bus.state_dbg), ST_MENU);
        chk("collide_exit", 32'(bus.exit_pulse), 32'd0);
        chk("collide_amount", 32'(bus.amount), 32'd0);

        // Logout via menu 0
        enter_num(0, 1);
        chk("logout_exit", 32'(bus.exit_pulse), 32'd1);
        chk("logout_state", 32'(bus.state_dbg), ST_ACC);
        chk("logout_acc", 32'(bus.acc_number), 32'd0);
        chk("logout_pin", 32'(bus.pin), 32'd0);

        // Account boundary 4096/4095, then async reset drops the pending login
        enter_num(4096, 4);
        chk("acc4096_err", 32'(bus.entry_error), 32'd1);
        enter_num(4095, 4);
        chk("acc4095_state", 32'(bus.state_dbg), ST_PIN);
        push(1'b0, 4095, 3, 0, 0, 0);
        enter_num(3, 1);
        wait_req(0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(bus.req_valid), 32'd0);
        chk("async_rst_state", 32'(bus.state_dbg), ST_ACC);
        chk("async_rst_acc", 32'(bus.acc_number), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Idle in S_PIN
        enter_num(1, 1);
        chk("idle_start_state", 32'(bus.state_dbg), ST_PIN);
`ifdef KEYPAD_TIMEOUT_EN
        repeat (19) @(negedge clk);
        chk("pre_timeout_state", 32'(bus.state_dbg), ST_PIN);
        @(negedge clk);
        chk("timeout_pulse", 32'(bus.timeout), 32'd1);
        chk("timeout_exit", 32'(bus.exit_pulse), 32'd1);
        chk("timeout_state", 32'(bus.state_dbg), ST_ACC);
`else
        repeat (25) @(negedge clk);
        chk("no_timeout", 32'(bus.timeout), 32'd0);
        chk("no_timeout_state", 32'(bus.state_dbg), ST_PIN);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
